// File: rtl/aer_rx_decoder_pkg.sv
// Shared types and helpers for the AER 2-bit serial receiver.
package aer_rx_decoder_pkg;

  // Receiver handshake FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_STALL = 2'd2
  } rx_state_t;

  // One serial symbol: {bit1, bit0}.
  typedef logic [1:0] sym_t;

  // Reference word width used when no override is given.
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_SYM_PER_WORD = DEF_ADDR_W / 2;

  // Symbols needed to build one address word.
  function automatic int sym_per_word(input int addr_w);
    return addr_w / 2;
  endfunction

endpackage

// File: rtl/aer_rx_decoder_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous link inputs.
// Cleared by the synchronous reset so no stale request survives a reset.
module aer_rx_decoder_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] pipe;

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/aer_rx_decoder.sv
// AER 2-bit serial link receiver: synchronizes {bit1,bit0}/dt, acknowledges
// each symbol with a 4-phase senack handshake, reassembles ADDR_W/2 symbols
// (MSB symbol first) into an address event, timestamps it, and presents it
// on a valid/ready port.  ADDR_W must be even and at least 4.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for dt; partial-word timeout runs here
//   ACK   | symbol latched, senack high until dt falls
//   STALL | final symbol pending, output register still occupied
module aer_rx_decoder
  import aer_rx_decoder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int TS_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit0,
  input  logic              bit1,
  input  logic              dt,
  output logic              senack,
  output logic [ADDR_W-1:0] evt_addr,
  output logic [TS_W-1:0]   evt_ts,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              timeout_err
);

  localparam int SPW   = sym_per_word(ADDR_W);
  localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SPW - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

  logic dt_s;
  logic bit0_s;
  logic bit1_s;
  sym_t sym_s;

  rx_state_t state;
  rx_state_t state_nxt;

  // The final symbol goes straight to the output register, so the shift
  // register only ever holds the first SPW-1 symbols.
  logic [ADDR_W-3:0] shreg;
  logic [ADDR_W-3:0] shreg_eff;
  logic [ADDR_W-1:0] word_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_eff;
  logic [TMR_W-1:0]  tmr;
  logic [TS_W-1:0]   ts;

  logic expire;
  logic last_sym;
  logic out_busy;
  logic capture;
  logic complete;
  logic tmr_run;

  aer_rx_decoder_sync #(.STAGES(SYNC_STAGES)) u_sync_dt (
    .clk   (clk),
    .reset (reset),
    .d     (dt),
    .q     (dt_s)
  );

  aer_rx_decoder_sync #(.STAGES(SYNC_STAGES)) u_sync_bit0 (
    .clk   (clk),
    .reset (reset),
    .d     (bit0),
    .q     (bit0_s)
  );

  aer_rx_decoder_sync #(.STAGES(SYNC_STAGES)) u_sync_bit1 (
    .clk   (clk),
    .reset (reset),
    .d     (bit1),
    .q     (bit1_s)
  );

  assign sym_s = {bit1_s, bit0_s};

  // Timer is a down-counter reloaded on every accepted symbol; reaching zero
  // while idle with a partial word means the transmitter went quiet.
  // Expiry takes priority over a symbol arriving in the same cycle: the
  // partial word is dropped and that symbol starts a fresh word.
  assign expire    = (state == S_IDLE) && (cnt != '0) && (tmr == '0);
  assign cnt_eff   = expire ? '0 : cnt;
  assign shreg_eff = expire ? '0 : shreg;
  assign word_nxt  = {shreg_eff, sym_s};
  assign last_sym  = (cnt_eff == LAST_SYM);
  assign out_busy  = evt_valid && !evt_ready;
  assign complete  = capture && last_sym;
  assign tmr_run   = (state == S_IDLE) && (cnt != '0) && !capture && !expire;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and symbol capture strobe.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dt_s) begin
          if (last_sym && out_busy) begin
            state_nxt = S_STALL;
          end else begin
            capture   = 1'b1;
            state_nxt = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!dt_s) begin
          state_nxt = S_IDLE;
        end
      end
      S_STALL: begin
        if (!dt_s) begin
          state_nxt = S_IDLE;
        end else if (!out_busy) begin
          capture   = 1'b1;
          state_nxt = S_ACK;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // senack is registered and simply mirrors residence in ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      senack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      senack      <= (state_nxt == S_ACK);
      timeout_err <= expire;
    end
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // Symbol assembly: shift register, symbol count and inter-symbol timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      tmr   <= '0;
    end else begin
      if (expire) begin
        shreg <= '0;
        cnt   <= '0;
      end
      if (capture) begin
        tmr <= TMR_LOAD;
        if (last_sym) begin
          shreg <= '0;
          cnt   <= '0;
        end else begin
          shreg <= word_nxt[ADDR_W-3:0];
          cnt   <= cnt_eff + 1'b1;
        end
      end else if (tmr_run) begin
        tmr <= tmr - 1'b1;
      end
    end
  end

  // Output event register: loads on word completion, clears on acceptance;
  // a completion in the same cycle as acceptance keeps valid asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_addr  <= '0;
      evt_ts    <= '0;
      evt_valid <= 1'b0;
    end else if (complete) begin
      evt_addr  <= word_nxt;
      evt_ts    <= ts;
      evt_valid <= 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aer_rx_decoder.sv
// Self-checking bench for aer_rx_decoder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_aer_rx_decoder;

  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;
  localparam int TS_W        = 16;
  localparam int SPW         = ADDR_W / 2;
  localparam int BOUND       = 2000;

  logic              clk;
  logic              reset;
  logic              bit0;
  logic              bit1;
  logic              dt;
  logic              senack;
  logic [ADDR_W-1:0] evt_addr;
  logic [TS_W-1:0]   evt_ts;
  logic              evt_valid;
  logic              evt_ready;
  logic              timeout_err;

  aer_rx_decoder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT),
    .TS_W        (TS_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit0        (bit0),
    .bit1        (bit1),
    .dt          (dt),
    .senack      (senack),
    .evt_addr    (evt_addr),
    .evt_ts      (evt_ts),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SYNC_STAGES-1:0] p_dt, p_b0, p_b1;
  bit m_ack, m_stalled, m_valid, m_senack, m_tout;
  int m_nsym, m_word, m_idle, m_addr, m_evts, m_ts;

  task automatic model_step();
    bit d, busy, load, was_stalled, expired;
    int b, new_addr;
    if (reset) begin
      p_dt = '0; p_b0 = '0; p_b1 = '0;
      m_ack = 0; m_stalled = 0; m_valid = 0; m_senack = 0; m_tout = 0;
      m_nsym = 0; m_word = 0; m_idle = 0; m_addr = 0; m_evts = 0; m_ts = 0;
      return;
    end
    d = p_dt[SYNC_STAGES-1];
    b = 2 * int'(p_b1[SYNC_STAGES-1]) + int'(p_b0[SYNC_STAGES-1]);
    busy = m_valid && !evt_ready;
    load = 0; new_addr = 0; m_tout = 0; was_stalled = m_stalled;
    if (m_ack) begin
      if (!d) m_ack = 0;
    end else begin
      expired = !was_stalled && m_nsym > 0 && m_idle == TIMEOUT;
      if (expired) begin
        m_nsym = 0; m_word = 0; m_idle = 0; m_tout = 1;
      end
      if (d) begin
        if (m_nsym == SPW - 1 && busy) begin
          m_stalled = 1;
        end else begin
          m_stalled = 0;
          m_word = ((m_word << 2) | b) & ((1 << ADDR_W) - 1);
          m_nsym++;
          m_idle = 0;
          m_ack = 1;
          if (m_nsym == SPW) begin
            load = 1; new_addr = m_word; m_nsym = 0; m_word = 0;
          end
        end
      end else begin
        m_stalled = 0;
        if (!expired && !was_stalled && m_nsym > 0) m_idle++;
      end
    end
    if (load) begin
      m_valid = 1; m_addr = new_addr; m_evts = m_ts;
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    m_ts = (m_ts + 1) & ((1 << TS_W) - 1);
    m_senack = m_ack;
    p_dt = {p_dt[SYNC_STAGES-2:0], dt};
    p_b0 = {p_b0[SYNC_STAGES-2:0], bit0};
    p_b1 = {p_b1[SYNC_STAGES-2:0], bit1};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  bit cmp_en = 0;
  bit prev_senack = 0;
  int ack_rises = 0;
  int valid_cycles = 0;
  int tout_pulses = 0;
  logic [ADDR_W-1:0] acc_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_senack", senack, m_senack);
        check("cyc_evt_valid", evt_valid, m_valid);
        check("cyc_evt_addr", evt_addr, m_addr);
        check("cyc_evt_ts", evt_ts, m_evts);
        check("cyc_timeout_err", timeout_err, m_tout);
        if (senack && !prev_senack) ack_rises++;
        prev_senack = senack;
        if (evt_valid) valid_cycles++;
        if (timeout_err) tout_pulses++;
        if (evt_valid && evt_ready) acc_q.push_back(evt_addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rnd_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_sym(input logic [1:0] s, output int lat);
    int n;
    bit1 = s[1];
    bit0 = s[0];
    tick();
    dt = 1'b1;
    lat = 0;
    while (!senack && lat < BOUND) begin
      tick();
      lat++;
    end
    check("sym_ack_seen", senack, 1'b1);
    dt = 1'b0;
    n = 0;
    while (senack && n < BOUND) begin
      tick();
      n++;
    end
    check("sym_ack_release", senack, 1'b0);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] w);
    int lat;
    for (int i = SPW - 1; i >= 0; i--) send_sym(w[2*i +: 2], lat);
  endtask

  function automatic int last_acc();
    if (acc_q.size() == 0) return -1;
    return int'(acc_q[$]);
  endfunction

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int lat, n0, n;
    reset = 1'b1; dt = 1'b0; bit0 = 1'b0; bit1 = 1'b0; evt_ready = 1'b0;
    tick(); tick();
    cmp_en = 1;
    tick();
    check("rst_senack", senack, 1'b0);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_addr", evt_addr, 8'h00);
    check("rst_evt_ts", evt_ts, 16'h0000);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // basic word 2,1,3,0 -> 9C
    evt_ready = 1'b1;
    ack_rises = 0; valid_cycles = 0;
    send_sym(2'd2, lat);
    check("t1_ack_latency", lat, 3);
    send_sym(2'd1, lat);
    send_sym(2'd3, lat);
    send_sym(2'd0, lat);
    repeat (4) tick();
    check("t1_addr", last_acc(), 8'h9C);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_ack_rises", ack_rises, 4);

    // back-pressure: A5 held, 3C final symbol stalls
    evt_ready = 1'b0;
    send_word(8'hA5);
    fork
      send_word(8'h3C);
      begin
        repeat (60) tick();
        check("t2_stall_senack", senack, 1'b0);
        check("t2_held_addr", evt_addr, 8'hA5);
        check("t2_held_valid", evt_valid, 1'b1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
      end
    join
    check("t2_acc_first", last_acc(), 8'hA5);
    check("t2_next_addr", evt_addr, 8'h3C);
    check("t2_next_valid", evt_valid, 1'b1);
    evt_ready = 1'b1;
    repeat (3) tick();
    check("t2_acc_second", last_acc(), 8'h3C);

    // timeout on a partial word, then a clean word 0,0,0,1
    tout_pulses = 0;
    n0 = acc_q.size();
    send_sym(2'd3, lat);
    send_sym(2'd3, lat);
    repeat (300) tick();
    check("t3_tout_pulses", tout_pulses, 1);
    check("t3_no_event", acc_q.size(), n0);
    send_word(8'h01);
    repeat (4) tick();
    check("t3_addr", last_acc(), 8'h01);

    // reset in the middle of a handshake
    n0 = acc_q.size();
    tout_pulses = 0;
    send_sym(2'd1, lat);
    send_sym(2'd2, lat);
    bit1 = 1'b1; bit0 = 1'b1;
    tick();
    dt = 1'b1;
    n = 0;
    while (!senack && n < BOUND) begin
      tick();
      n++;
    end
    check("t4_ack_before_reset", senack, 1'b1);
    reset = 1'b1;
    dt = 1'b0;
    tick();
    check("t4_senack_dropped", senack, 1'b0);
    check("t4_no_valid", evt_valid, 1'b0);
    reset = 1'b0;
    repeat (5) tick();
    check("t4_no_event", acc_q.size(), n0);
    check("t4_no_tout", tout_pulses, 0);
    send_word(8'h5A);
    repeat (4) tick();
    check("t4_addr", last_acc(), 8'h5A);

    // completion coinciding with acceptance of a held event
    evt_ready = 1'b0;
    send_word(8'h96);
    send_sym(2'd1, lat);
    send_sym(2'd0, lat);
    send_sym(2'd2, lat);
    bit1 = 1'b1; bit0 = 1'b1;
    tick();
    dt = 1'b1;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t5_senack", senack, 1'b1);
    check("t5_valid_kept", evt_valid, 1'b1);
    check("t5_new_addr", evt_addr, 8'h4B);
    check("t5_old_accepted", last_acc(), 8'h96);
    dt = 1'b0;
    n = 0;
    while (senack && n < BOUND) begin
      tick();
      n++;
    end
    check("t5_ack_release", senack, 1'b0);
    evt_ready = 1'b1;
    repeat (3) tick();
    check("t5_acc_new", last_acc(), 8'h4B);

    // random traffic with random back-pressure and occasional long gaps
    rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < SPW; j++) begin
        int gap;
        send_sym(2'($urandom_range(0, 3)), lat);
        gap = ($urandom_range(0, 9) == 0) ? 270 : int'($urandom_range(0, 4));
        repeat (gap) tick();
      end
    end
    rnd_ready = 0;
    evt_ready = 1'b1;
    repeat (8) tick();
    check("rnd_drained", evt_valid, 1'b0);

    // timestamp wrap: final symbol captured when ts = FFFF
    n = 0;
    while (m_ts != 'hFF40 && n < 70000) begin
      tick();
      n++;
    end
    check("t7_ts_reached", m_ts, 'hFF40);
    send_sym(2'd3, lat);
    send_sym(2'd0, lat);
    send_sym(2'd0, lat);
    n = 0;
    while (m_ts != 'hFFFD && n < 1000) begin
      tick();
      n++;
    end
    bit1 = 1'b1; bit0 = 1'b1;
    dt = 1'b1;
    repeat (3) tick();
    check("t7_valid", evt_valid, 1'b1);
    check("t7_evt_ts", evt_ts, 16'hFFFF);
    check("t7_evt_addr", evt_addr, 8'hC3);
    dt = 1'b0;
    repeat (6) tick();
    send_word(8'h77);
    repeat (4) tick();
    check("t7_after_wrap", last_acc(), 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
